// File: rtl/median5_pkg.sv
// ---------------------------------------------------------------------------
// median5_pkg
// Constants and types shared by the median-5 window feeder and its tap
// shift register.
//   DW        : sample width, must match the downstream median selector
//   WIN       : window length (fixed at 5)
//   state_t   : line framing states of the feeder
//   tap_op_t  : control word for the tap shift register
//   FILL_FULL : fill count at which the window is fully populated
//   FLUSH_LEN : number of trailing padded windows for lines of 2+ samples
// ---------------------------------------------------------------------------
package median5_pkg;

   localparam int DW  = 8;
   localparam int WIN = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TAP_HOLD  = 2'd0,
      TAP_SHIFT = 2'd1,
      TAP_LOAD  = 2'd2
   } tap_op_t;

   localparam logic [1:0] FILL_FULL = 2'd3;
   localparam logic [1:0] FLUSH_LEN = 2'd2;

   // Count of samples seen in the current line, saturating once the
   // window has enough real samples to be centred.
   function automatic logic [1:0] fill_step(input logic [1:0] cnt);
      if (cnt >= FILL_FULL) begin
         return FILL_FULL;
      end
      return cnt + 2'd1;
   endfunction

endpackage

// File: rtl/median5_tap_shift.sv
// ---------------------------------------------------------------------------
// median5_tap_shift
// Five-tap sample shift register feeding the median selector window.
// Ports:
//   clk, ngreset : clock and asynchronous active-low reset (taps clear to 0)
//   op           : TAP_HOLD keeps all taps, TAP_SHIFT moves every tap one
//                  place older and puts din in w0, TAP_LOAD copies din into
//                  all five taps (edge replication at the start of a line)
//   din          : sample entering the newest tap
//   w0..w4       : taps, w0 newest, w4 oldest
// ---------------------------------------------------------------------------
module median5_tap_shift
   import median5_pkg::*;
#(
   parameter int W = median5_pkg::DW
) (
   input  logic         clk,
   input  logic         ngreset,
   input  tap_op_t      op,
   input  logic [W-1:0] din,
   output logic [W-1:0] w0,
   output logic [W-1:0] w1,
   output logic [W-1:0] w2,
   output logic [W-1:0] w3,
   output logic [W-1:0] w4
);

   // Tap storage. Loading all taps at once is what gives the line its
   // replicated left edge; replicating on the right edge is done by the
   // feeder simply shifting w0 back into itself.
   always_ff @(posedge clk or negedge ngreset) begin
      if (!ngreset) begin
         w0 <= '0;
         w1 <= '0;
         w2 <= '0;
         w3 <= '0;
         w4 <= '0;
      end else begin
         case (op)
            TAP_LOAD: begin
               w0 <= din;
               w1 <= din;
               w2 <= din;
               w3 <= din;
               w4 <= din;
            end
            TAP_SHIFT: begin
               w4 <= w3;
               w3 <= w2;
               w2 <= w1;
               w1 <= w0;
               w0 <= din;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/median5_window_feeder.sv
// ---------------------------------------------------------------------------
// median5_window_feeder
// Turns a line-framed serial sample stream into a sliding, centred 5-tap
// window for the median selector. Line edges are padded by replicating the
// first and last samples, so every input sample yields exactly one window.
// Ports:
//   clk, ngreset     : clock and asynchronous active-low reset
//   in_valid/in_data : input sample, accepted when in_valid && in_ready
//   in_sof / in_eol  : first / last sample of a line (may coincide)
//   in_ready         : low while trailing padded windows are flushed
//   data0..data4     : window taps, data0 newest, data2 centre, data4 oldest
//   win_valid        : taps hold a valid centred window this cycle
//   win_eol          : with win_valid, last window of the line
//   line_err         : one-cycle pulse for a sample without a line start,
//                      or a new line start before the previous line ended
// ---------------------------------------------------------------------------
module median5_window_feeder
   import median5_pkg::*;
#(
   parameter int DW = median5_pkg::DW
) (
   input  logic          clk,
   input  logic          ngreset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_sof,
   input  logic          in_eol,
   output logic          in_ready,
   output logic [DW-1:0] data0,
   output logic [DW-1:0] data1,
   output logic [DW-1:0] data2,
   output logic [DW-1:0] data3,
   output logic [DW-1:0] data4,
   output logic          win_valid,
   output logic          win_eol,
   output logic          line_err
);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    fill_cnt;
   logic [1:0]    fill_nxt;
   logic [1:0]    fill_after;
   logic [1:0]    flush_cnt;
   logic [1:0]    flush_nxt;
   logic          valid_nxt;
   logic          eol_nxt;
   logic          err_nxt;
   logic          start;
   logic          accept;
   tap_op_t       tap_op;
   logic [DW-1:0] tap_din;

   // The source is only stalled while the padded trailing windows are
   // produced, so the ready is a pure decode of the registered state.
   assign in_ready = (state != FLUSH);
   assign accept   = in_valid && in_ready;

   // Window storage; the FSM below decides each cycle whether it loads,
   // shifts or holds.
   median5_tap_shift #(
      .W (DW)
   ) u_taps (
      .clk     (clk),
      .ngreset (ngreset),
      .op      (tap_op),
      .din     (tap_din),
      .w0      (data0),
      .w1      (data1),
      .w2      (data2),
      .w3      (data3),
      .w4      (data4)
   );

   // Next-state and output decode. A line start (from IDLE, or a restart
   // in the middle of a line) fills all taps with the first sample so the
   // left edge is already padded. Inside a line the window only becomes
   // valid once three real samples have been taken, because only then is
   // the centre tap a real sample with two newer neighbours. On the end of
   // line, FLUSH shifts the last sample back into w0 to pad the right edge:
   // two extra windows normally, one when the line held a single sample.
   always_comb begin
      state_nxt  = state;
      fill_nxt   = fill_cnt;
      flush_nxt  = flush_cnt;
      valid_nxt  = 1'b0;
      eol_nxt    = 1'b0;
      err_nxt    = 1'b0;
      start      = 1'b0;
      tap_op     = TAP_HOLD;
      tap_din    = in_data;
      fill_after = fill_step(fill_cnt);

      case (state)
         IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  start = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end

         RUN: begin
            if (accept) begin
               if (in_sof) begin
                  err_nxt = 1'b1;
                  start   = 1'b1;
               end else begin
                  tap_op    = TAP_SHIFT;
                  fill_nxt  = fill_after;
                  valid_nxt = (fill_after == FILL_FULL);
                  if (in_eol) begin
                     state_nxt = FLUSH;
                     flush_nxt = (fill_after >= 2'd2) ? FLUSH_LEN : 2'd1;
                  end
               end
            end
         end

         FLUSH: begin
            tap_op    = TAP_SHIFT;
            tap_din   = data0;
            valid_nxt = 1'b1;
            flush_nxt = flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) begin
               eol_nxt   = 1'b1;
               state_nxt = IDLE;
               fill_nxt  = 2'd0;
               flush_nxt = 2'd0;
            end
         end

         default: begin
            state_nxt = IDLE;
            fill_nxt  = 2'd0;
            flush_nxt = 2'd0;
         end
      endcase

      if (start) begin
         tap_op   = TAP_LOAD;
         fill_nxt = 2'd1;
         if (in_eol) begin
            state_nxt = FLUSH;
            flush_nxt = 2'd1;
         end else begin
            state_nxt = RUN;
         end
      end
   end

   // State, counters and the registered window flags. Reset drops any
   // partially built window immediately.
   always_ff @(posedge clk or negedge ngreset) begin
      if (!ngreset) begin
         state     <= IDLE;
         fill_cnt  <= 2'd0;
         flush_cnt <= 2'd0;
         win_valid <= 1'b0;
         win_eol   <= 1'b0;
         line_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_nxt;
         flush_cnt <= flush_nxt;
         win_valid <= valid_nxt;
         win_eol   <= eol_nxt;
         line_err  <= err_nxt;
      end
   end

endmodule
